// File: rtl/counter_seq.sv
// counter_seq: command sequencer that drives a 5-bit loadable counter.
// A host issues LOAD / RUN / RUN_TO / NOP commands over a valid/ready
// handshake. The block drives the counter's load/data/enable pins and watches
// its count output to close the RUN_TO loop. Completion is reported as a
// one-cycle done pulse. Timeout or abort is reported as a one-cycle err pulse.
module counter_seq #(
  parameter int WIDTH = 5,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_RUN_TO = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_RUN_TO = 2'b11;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

  // FSM state and captured command fields
  state_t           state_q, state_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [LEN_W-1:0] rem_q, rem_d;      // cycles left in RUN, or timeout budget in RUN_TO
  logic             timed_q, timed_d;  // RUN_TO has a nonzero timeout
  logic             fin_err_d;         // the FIN being entered reports err rather than done

  // Registered outputs
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Decoded handshake and loop-closing terms
  logic ready_s;
  logic accept_s;
  logic match_s;
  logic enable_s;

  // Handshake: commands are taken only when idle and out of reset.
  always_comb begin
    ready_s  = rst && (state_q == ST_IDLE);
    accept_s = cmd_valid && ready_s;
    match_s  = (count == arg_q);
  end

  // Count enable must follow the live count so RUN_TO stops on the exact
  // cycle the target appears; an abort suppresses it in the same cycle.
  always_comb begin
    enable_s = 1'b0;
    case (state_q)
      ST_RUN:    enable_s = !cmd_abort;
      ST_RUN_TO: enable_s = !cmd_abort && !match_s;
      default:   enable_s = 1'b0;
    endcase
  end

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    arg_d     = arg_q;
    rem_d     = rem_q;
    timed_d   = timed_q;
    fin_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          arg_d   = cmd_arg;
          rem_d   = cmd_len;
          timed_d = (cmd_len != LEN_ZERO);
          case (cmd_op)
            OP_NOP:    state_d = ST_FIN;
            OP_LOAD:   state_d = ST_LOAD;
            OP_RUN: begin
              if (cmd_len == LEN_ZERO) begin
                state_d = ST_FIN;
              end else begin
                state_d = ST_RUN;
              end
            end
            OP_RUN_TO: state_d = ST_RUN_TO;
            default:   state_d = ST_FIN;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        state_d = ST_FIN;
      end

      ST_RUN: begin
        if (cmd_abort) begin
          state_d   = ST_FIN;
          fin_err_d = 1'b1;
        end else if (rem_q == LEN_ONE) begin
          state_d = ST_FIN;
        end else begin
          rem_d = rem_q - LEN_ONE;
        end
      end

      ST_RUN_TO: begin
        if (cmd_abort) begin
          state_d   = ST_FIN;
          fin_err_d = 1'b1;
        end else if (match_s) begin
          state_d = ST_FIN;
        end else if (timed_q && (rem_q == LEN_ONE)) begin
          // This cycle is the last permitted enable cycle.
          state_d   = ST_FIN;
          fin_err_d = 1'b1;
        end else if (timed_q) begin
          rem_d = rem_q - LEN_ONE;
        end else begin
          rem_d = rem_q;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are a registered decode of the state being entered.
    load_d = (state_d == ST_LOAD);
    data_d = (state_d == ST_LOAD) ? arg_d : data_q;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN) && !fin_err_d;
    err_d  = (state_d == ST_FIN) && fin_err_d;
  end

  // Sequencer state and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      arg_q   <= {WIDTH{1'b0}};
      rem_q   <= {LEN_W{1'b0}};
      timed_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      timed_q <= timed_d;
      data_q  <= data_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Drive the output ports.
  always_comb begin
    cmd_ready = ready_s;
    load      = load_q;
    data      = data_q;
    enable    = enable_s;
    busy      = busy_q;
    done      = done_q;
    err       = err_q;
  end

endmodule
